// File: rtl/complete_buffered.sv
// Buffered completion stage: per-channel FIFOs for C execute channels, drained
// round-robin onto N registered ROB update lanes, with stall and squash support.
`ifndef N
`define N 2
`endif

package complete_buffered_pkg;
    localparam int ROB_N     = `N;
    localparam int ROB_IDX_W = 6;
    localparam int PR_W      = 7;
    localparam int XLEN      = 32;

    typedef struct packed {
        logic [ROB_IDX_W-1:0] rob_idx;
        logic                 branch_valid;
        logic                 branch_taken;
        logic [XLEN-1:0]      branch_target;
        logic                 mispredict;
        logic [PR_W-1:0]      dest_pr;
        logic [XLEN-1:0]      result;
    } EX_COMPLETE_ENTRY;

    typedef struct packed {
        logic [ROB_N-1:0]                valid;
        logic [ROB_N-1:0][ROB_IDX_W-1:0] idx;
        logic [ROB_N-1:0]                branch_taken;
        logic [ROB_N-1:0][XLEN-1:0]      branch_targets;
    } ROB_UPDATE_PACKET;
endpackage

module complete_buffered
    import complete_buffered_pkg::*;
#(
    parameter int N     = `N,
    parameter int C     = 2 * N,
    parameter int DEPTH = 2
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [C-1:0]              ex_valid,
    input  EX_COMPLETE_ENTRY [C-1:0]  ex_comp,
    output logic [C-1:0]              ex_ready,
    input  logic                      rob_stall,
    input  logic                      flush,
    output ROB_UPDATE_PACKET          rob_update_packet,
    output logic                      overflow_err
);
    localparam int CH_W  = (C > 1) ? $clog2(C) : 1;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Branch gating is applied on entry so the FIFO only holds what the ROB needs.
    typedef struct packed {
        logic [ROB_IDX_W-1:0] idx;
        logic                 taken;
        logic [XLEN-1:0]      target;
    } slot_t;

    slot_t            mem    [C][DEPTH];
    slot_t            in_slot[C];
    logic [PTR_W-1:0] rd_ptr [C];
    logic [PTR_W-1:0] wr_ptr [C];
    logic [CNT_W-1:0] count  [C];
    logic [CH_W-1:0]  rr_ptr;
    logic [CH_W-1:0]  rr_next;
    logic [CH_W-1:0]  last_ch;
    logic [CH_W-1:0]  lane_chan[N];
    logic [N-1:0]     lane_valid;
    logic [C-1:0]     grant;
    logic [C-1:0]     push;
    ROB_UPDATE_PACKET out_next;
    logic             unused_fields;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        unused_fields = 1'b0;
        for (int c = 0; c < C; c++) begin
            ex_ready[c]       = (count[c] < CNT_W'(DEPTH));
            push[c]           = ex_valid[c] & ex_ready[c];
            in_slot[c].idx    = ex_comp[c].rob_idx;
            in_slot[c].taken  = ex_comp[c].branch_valid & ex_comp[c].branch_taken;
            in_slot[c].target = ex_comp[c].branch_valid ? ex_comp[c].branch_target : '0;
            unused_fields     = unused_fields ^ (^{ex_comp[c].mispredict,
                                                   ex_comp[c].dest_pr,
                                                   ex_comp[c].result});
        end
    end

    // Round-robin scan from rr_ptr; the k-th grant lands on lane k.
    always_comb begin
        int n;
        int ch;
        grant      = '0;
        lane_valid = '0;
        last_ch    = '0;
        n          = 0;
        ch         = 0;
        for (int k = 0; k < N; k++) lane_chan[k] = '0;
        if (!rob_stall && !flush) begin
            for (int i = 0; i < C; i++) begin
                ch = (int'(rr_ptr) + i) % C;
                if (n < N && count[ch] != '0) begin
                    grant[ch]     = 1'b1;
                    lane_valid[n] = 1'b1;
                    lane_chan[n]  = CH_W'(ch);
                    last_ch       = CH_W'(ch);
                    n             = n + 1;
                end
            end
        end
        rr_next = (last_ch == CH_W'(C - 1)) ? '0 : last_ch + CH_W'(1);
    end

    always_comb begin
        out_next = '0;
        for (int k = 0; k < N; k++) begin
            if (lane_valid[k]) begin
                out_next.valid[k]          = 1'b1;
                out_next.idx[k]            = mem[lane_chan[k]][rd_ptr[lane_chan[k]]].idx;
                out_next.branch_taken[k]   = mem[lane_chan[k]][rd_ptr[lane_chan[k]]].taken;
                out_next.branch_targets[k] = mem[lane_chan[k]][rd_ptr[lane_chan[k]]].target;
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int c = 0; c < C; c++) begin
            if (push[c] && !flush) mem[c][wr_ptr[c]] <= in_slot[c];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < C; c++) begin
                count[c]  <= '0;
                rd_ptr[c] <= '0;
                wr_ptr[c] <= '0;
            end
            rr_ptr            <= '0;
            rob_update_packet <= '0;
            overflow_err      <= 1'b0;
        end else if (flush) begin
            // Squash keeps the sticky error so a protocol violation is never hidden.
            for (int c = 0; c < C; c++) begin
                count[c]  <= '0;
                rd_ptr[c] <= '0;
                wr_ptr[c] <= '0;
            end
            rr_ptr            <= '0;
            rob_update_packet <= '0;
        end else begin
            for (int c = 0; c < C; c++) begin
                if (push[c])  wr_ptr[c] <= ptr_inc(wr_ptr[c]);
                if (grant[c]) rd_ptr[c] <= ptr_inc(rd_ptr[c]);
                if (push[c] && !grant[c])      count[c] <= count[c] + CNT_W'(1);
                else if (!push[c] && grant[c]) count[c] <= count[c] - CNT_W'(1);
            end
            if (|(ex_valid & ~ex_ready)) overflow_err <= 1'b1;
            if (|grant) rr_ptr <= rr_next;
            rob_update_packet <= out_next;
        end
    end
endmodule

// File: tb/tb_complete_buffered.sv
// Self-checking bench for complete_buffered (N=2, C=4, DEPTH=2): directed corner
// sequences, a branch-gating vector table and a randomized queue-model phase.
module tb_complete_buffered;
    import complete_buffered_pkg::*;

    localparam int N = 2;
    localparam int C = 4;
    localparam int DEPTH = 2;

    logic                     clock;
    logic                     reset_n;
    logic [C-1:0]             ex_valid;
    EX_COMPLETE_ENTRY [C-1:0] ex_comp;
    logic [C-1:0]             ex_ready;
    logic                     rob_stall;
    logic                     flush;
    ROB_UPDATE_PACKET         pkt;
    logic                     overflow_err;

    complete_buffered #(.N(N), .C(C), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n), .ex_valid(ex_valid), .ex_comp(ex_comp),
        .ex_ready(ex_ready), .rob_stall(rob_stall), .flush(flush),
        .rob_update_packet(pkt), .overflow_err(overflow_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one queue per channel of already-gated ROB fields.
    typedef struct {
        logic [5:0]  idx;
        logic        tk;
        logic [31:0] tgt;
    } mentry_t;

    mentry_t     mq[C][$];
    int          m_rr;
    logic        m_ovf;
    logic [N-1:0] e_valid;
    logic [5:0]  e_idx[N];
    logic        e_tk[N];
    logic [31:0] e_tgt[N];

    typedef struct {
        logic [5:0]  idx;
        logic        bv;
        logic        bt;
        logic        mp;
        logic [31:0] tgt;
        logic        exp_tk;
        logic [31:0] exp_tgt;
    } gate_vec_t;
    gate_vec_t gv[4];

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic EX_COMPLETE_ENTRY mk(input logic [5:0] idx, input logic bv, input logic bt,
                                            input logic [31:0] tgt, input logic mp);
        EX_COMPLETE_ENTRY e;
        e.rob_idx       = idx;
        e.branch_valid  = bv;
        e.branch_taken  = bt;
        e.branch_target = tgt;
        e.mispredict    = mp;
        e.dest_pr       = PR_W'($urandom);
        e.result        = $urandom;
        return e;
    endfunction

    task automatic clear_exp();
        e_valid = '0;
        for (int k = 0; k < N; k++) begin
            e_idx[k] = '0;
            e_tk[k]  = 1'b0;
            e_tgt[k] = '0;
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < C; c++) mq[c].delete();
        m_rr  = 0;
        m_ovf = 1'b0;
        clear_exp();
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        logic [C-1:0] rdy;
        int k;
        int last;
        for (int c = 0; c < C; c++) rdy[c] = (mq[c].size() < DEPTH);
        clear_exp();
        if (flush) begin
            for (int c = 0; c < C; c++) mq[c].delete();
            m_rr = 0;
            return;
        end
        k = 0;
        last = 0;
        if (!rob_stall) begin
            for (int i = 0; i < C; i++) begin
                int ch;
                ch = (m_rr + i) % C;
                if (k < N && mq[ch].size() > 0) begin
                    mentry_t e;
                    e = mq[ch].pop_front();
                    e_valid[k] = 1'b1;
                    e_idx[k]   = e.idx;
                    e_tk[k]    = e.tk;
                    e_tgt[k]   = e.tgt;
                    last = ch;
                    k++;
                end
            end
            if (k > 0) m_rr = (last + 1) % C;
        end
        for (int c = 0; c < C; c++) begin
            if (ex_valid[c]) begin
                if (rdy[c]) begin
                    mentry_t e;
                    e.idx = ex_comp[c].rob_idx;
                    e.tk  = ex_comp[c].branch_valid & ex_comp[c].branch_taken;
                    e.tgt = ex_comp[c].branch_valid ? ex_comp[c].branch_target : 32'h0;
                    mq[c].push_back(e);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    endtask

    task automatic compare_model();
        logic [C-1:0] rdy;
        for (int c = 0; c < C; c++) rdy[c] = (mq[c].size() < DEPTH);
        check("valid", 64'(pkt.valid), 64'(e_valid));
        for (int k = 0; k < N; k++) begin
            check("idx", 64'(pkt.idx[k]), 64'(e_idx[k]));
            check("branch_taken", 64'(pkt.branch_taken[k]), 64'(e_tk[k]));
            check("branch_targets", 64'(pkt.branch_targets[k]), 64'(e_tgt[k]));
        end
        check("ex_ready", 64'(ex_ready), 64'(rdy));
        check("overflow_err", 64'(overflow_err), 64'(m_ovf));
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        compare_model();
    endtask

    task automatic clear_inputs();
        ex_valid  = '0;
        rob_stall = 1'b0;
        flush     = 1'b0;
        for (int c = 0; c < C; c++) ex_comp[c] = mk(6'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic push(input int ch, input logic [5:0] idx);
        ex_valid[ch] = 1'b1;
        ex_comp[ch]  = mk(idx, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        gv[0] = '{idx: 6'd20, bv: 1'b0, bt: 1'b1, mp: 1'b0, tgt: 32'h0000_0100, exp_tk: 1'b0, exp_tgt: 32'h0};
        gv[1] = '{idx: 6'd21, bv: 1'b1, bt: 1'b0, mp: 1'b1, tgt: 32'h4444_0000, exp_tk: 1'b0, exp_tgt: 32'h4444_0000};
        gv[2] = '{idx: 6'd22, bv: 1'b1, bt: 1'b1, mp: 1'b0, tgt: 32'hDEAD_BEE0, exp_tk: 1'b1, exp_tgt: 32'hDEAD_BEE0};
        gv[3] = '{idx: 6'd23, bv: 1'b0, bt: 1'b0, mp: 1'b1, tgt: 32'hFFFF_FFFF, exp_tk: 1'b0, exp_tgt: 32'h0};

        // Reset state
        reset_n = 1'b0;
        clear_inputs();
        model_reset();
        #1;
        check("reset_valid", 64'(pkt.valid), 64'h0);
        check("reset_idx", 64'(pkt.idx), 64'h0);
        check("reset_taken", 64'(pkt.branch_taken), 64'h0);
        check("reset_targets", 64'(pkt.branch_targets), 64'h0);
        check("reset_ex_ready", 64'(ex_ready), 64'hF);
        check("reset_overflow", 64'(overflow_err), 64'h0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        // Single entry: two-edge latency, one-cycle valid
        push(0, 6'd42);
        tick();
        clear_inputs();
        check("single_no_bypass", 64'(pkt.valid), 64'h0);
        tick();
        check("single_valid", 64'(pkt.valid), 64'h1);
        check("single_idx", 64'(pkt.idx[0]), 64'd42);
        check("single_taken", 64'(pkt.branch_taken[0]), 64'h0);
        check("single_target", 64'(pkt.branch_targets[0]), 64'h0);
        tick();
        check("single_gone", 64'(pkt.valid), 64'h0);

        // Flush with a push into a full channel: no overflow, rr_ptr back to 0
        rob_stall = 1'b1;
        push(1, 6'd5);
        tick();
        push(1, 6'd6);
        tick();
        check("full_not_ready", 64'(ex_ready[1]), 64'h0);
        flush = 1'b1;
        push(1, 6'd7);
        tick();
        clear_inputs();
        check("flush_push_no_ovf", 64'(overflow_err), 64'h0);
        check("flush_ready", 64'(ex_ready), 64'hF);

        // Arbitration across all four channels from rr_ptr=0
        for (int c = 0; c < C; c++) push(c, 6'(10 + c));
        tick();
        clear_inputs();
        tick();
        check("arb1_valid", 64'(pkt.valid), 64'h3);
        check("arb1_lane0", 64'(pkt.idx[0]), 64'd10);
        check("arb1_lane1", 64'(pkt.idx[1]), 64'd11);
        tick();
        check("arb2_lane0", 64'(pkt.idx[0]), 64'd12);
        check("arb2_lane1", 64'(pkt.idx[1]), 64'd13);
        check("arb_ready", 64'(ex_ready), 64'hF);
        // rr_ptr=0 means ch1 is reached before ch3
        push(3, 6'd14);
        push(1, 6'd15);
        tick();
        clear_inputs();
        tick();
        check("rr_order_lane0", 64'(pkt.idx[0]), 64'd15);
        check("rr_order_lane1", 64'(pkt.idx[1]), 64'd14);

        // Branch gating vectors
        for (int i = 0; i < 4; i++) begin
            ex_valid[i] = 1'b1;
            ex_comp[i]  = mk(gv[i].idx, gv[i].bv, gv[i].bt, gv[i].tgt, gv[i].mp);
            tick();
            clear_inputs();
            tick();
            check("gate_valid", 64'(pkt.valid), 64'h1);
            check("gate_idx", 64'(pkt.idx[0]), 64'(gv[i].idx));
            check("gate_taken", 64'(pkt.branch_taken[0]), 64'(gv[i].exp_tk));
            check("gate_target", 64'(pkt.branch_targets[0]), 64'(gv[i].exp_tgt));
        end
        tick();

        // Backpressure and overflow
        rob_stall = 1'b1;
        push(1, 6'd1);
        tick();
        check("bp_ready_after1", 64'(ex_ready[1]), 64'h1);
        push(1, 6'd2);
        tick();
        check("bp_not_ready", 64'(ex_ready[1]), 64'h0);
        check("bp_no_valid", 64'(pkt.valid), 64'h0);
        push(1, 6'd3);
        tick();
        check("bp_overflow", 64'(overflow_err), 64'h1);
        check("bp_still_no_valid", 64'(pkt.valid), 64'h0);
        clear_inputs();
        tick();
        check("bp_rel1_valid", 64'(pkt.valid), 64'h1);
        check("bp_rel1_idx", 64'(pkt.idx[0]), 64'd1);
        tick();
        check("bp_rel2_valid", 64'(pkt.valid), 64'h1);
        check("bp_rel2_idx", 64'(pkt.idx[0]), 64'd2);
        tick();
        check("bp_idx3_dropped", 64'(pkt.valid), 64'h0);

        // Flush with buffered entries and a concurrent push
        rob_stall = 1'b1;
        push(0, 6'd30);
        push(2, 6'd32);
        tick();
        clear_inputs();
        flush = 1'b1;
        push(3, 6'd33);
        tick();
        clear_inputs();
        check("flush_valid", 64'(pkt.valid), 64'h0);
        check("flush_ready_all", 64'(ex_ready), 64'hF);
        check("flush_ovf_kept", 64'(overflow_err), 64'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("flush_quiet", 64'(pkt.valid), 64'h0);
        end

        // Randomized traffic against the model
        for (int cyc = 0; cyc < 600; cyc++) begin
            ex_valid  = C'($urandom_range(0, 15));
            rob_stall = ($urandom_range(0, 3) == 0);
            flush     = ($urandom_range(0, 31) == 0);
            for (int c = 0; c < C; c++)
                ex_comp[c] = mk(6'($urandom), 1'($urandom), 1'($urandom), $urandom, 1'($urandom));
            tick();
        end
        clear_inputs();

        // Reset asserted mid-stream
        for (int c = 0; c < C; c++) push(c, 6'(40 + c));
        tick();
        clear_inputs();
        tick();
        check("pre_reset_valid", 64'(pkt.valid), 64'h3);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check("midreset_valid", 64'(pkt.valid), 64'h0);
        check("midreset_idx", 64'(pkt.idx), 64'h0);
        check("midreset_ready", 64'(ex_ready), 64'hF);
        check("midreset_ovf", 64'(overflow_err), 64'h0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            ex_valid  = C'($urandom_range(0, 15));
            rob_stall = ($urandom_range(0, 3) == 0);
            flush     = 1'b0;
            for (int c = 0; c < C; c++)
                ex_comp[c] = mk(6'($urandom), 1'($urandom), 1'($urandom), $urandom, 1'($urandom));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
